// File: rtl/mmio_port_responder.sv
// Memory-mapped I/O responder: output port, synchronized input port with sticky
// rising-edge capture, and a compare timer, all behind a 32-byte register window.
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int          IN_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  output logic [31:0]         ReadData,
  output logic                Hit,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut,
  output logic                Irq
);

  localparam logic [2:0] IDX_PORT_OUT  = 3'd0;
  localparam logic [2:0] IDX_PORT_IN   = 3'd1;
  localparam logic [2:0] IDX_EDGE      = 3'd2;
  localparam logic [2:0] IDX_EDGE_MASK = 3'd3;
  localparam logic [2:0] IDX_CTRL      = 3'd4;
  localparam logic [2:0] IDX_COUNT     = 3'd5;
  localparam logic [2:0] IDX_CMP       = 3'd6;
  localparam logic [2:0] IDX_STATUS    = 3'd7;

  logic                sel;
  logic [2:0]          idx;
  logic                wr;
  logic                rd;

  logic [31:0]         port_out;
  logic [IN_WIDTH-1:0] sync1;
  logic [IN_WIDTH-1:0] sync;
  logic [IN_WIDTH-1:0] prev;
  logic [IN_WIDTH-1:0] edges;
  logic [IN_WIDTH-1:0] edge_mask;
  logic [1:0]          ctrl;
  logic [31:0]         count;
  logic [31:0]         cmp;
  logic                tick;

  logic [IN_WIDTH-1:0] rise;
  logic                cmp_hit;
  logic [31:0]         rd_word;

  assign sel     = (Address[31:5] == BASE_ADDR[31:5]) && (Address[1:0] == 2'b00);
  assign idx     = Address[4:2];
  assign wr      = sel && MemWrite;
  assign rd      = sel && MemRead && !MemWrite;
  assign rise    = sync & ~prev;
  assign cmp_hit = ctrl[0] && (count == cmp);

  // Input synchronizer plus one-cycle-delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync  <= '0;
      prev  <= '0;
    end else begin
      sync1 <= PortIn;
      sync  <= sync1;
      prev  <= sync;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port_out  <= '0;
      edges     <= '0;
      edge_mask <= '0;
      ctrl      <= '0;
    end else begin
      if (wr && idx == IDX_PORT_OUT)  port_out  <= WriteData;
      if (wr && idx == IDX_EDGE_MASK) edge_mask <= WriteData[IN_WIDTH-1:0];
      if (wr && idx == IDX_CTRL)      ctrl      <= WriteData[1:0];
      // Clear first, then OR in new rises so a coincident set wins.
      if (wr && idx == IDX_EDGE)
        edges <= (edges & ~WriteData[IN_WIDTH-1:0]) | rise;
      else
        edges <= edges | rise;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      cmp   <= 32'hFFFF_FFFF;
      tick  <= 1'b0;
    end else begin
      if (wr && idx == IDX_CMP) cmp <= WriteData;
      if (wr && idx == IDX_COUNT)
        count <= WriteData;
      else if (cmp_hit)
        count <= '0;
      else if (ctrl[0])
        count <= count + 32'd1;
      if (cmp_hit)
        tick <= 1'b1;
      else if (wr && idx == IDX_STATUS && WriteData[0])
        tick <= 1'b0;
    end
  end

  always_comb begin
    rd_word = '0;
    case (idx)
      IDX_PORT_OUT:  rd_word = port_out;
      IDX_PORT_IN:   rd_word[IN_WIDTH-1:0] = sync;
      IDX_EDGE:      rd_word[IN_WIDTH-1:0] = edges;
      IDX_EDGE_MASK: rd_word[IN_WIDTH-1:0] = edge_mask;
      IDX_CTRL:      rd_word[1:0] = ctrl;
      IDX_COUNT:     rd_word = count;
      IDX_CMP:       rd_word = cmp;
      IDX_STATUS:    rd_word[0] = tick;
      default:       rd_word = '0;
    endcase
  end

  // Read data is a one-cycle pulse; it returns to zero whenever no read is selected.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ReadData <= '0;
      Hit      <= 1'b0;
    end else begin
      ReadData <= rd ? rd_word : 32'd0;
      Hit      <= rd;
    end
  end

  assign PortOut = port_out;
  assign Irq     = (tick & ctrl[1]) | (|(edges & edge_mask));

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed bench for mmio_port_responder: register map, port paths, timer and
// read/write corner cases checked with immediate assertions.
module tb_mmio_port_responder;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Hit;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic        Irq;

  int n_assert = 0;
  int n_fail   = 0;

  mmio_port_responder #(.BASE_ADDR(BASE), .IN_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData), .Hit(Hit),
    .PortIn(PortIn), .PortOut(PortOut), .Irq(Irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic hit);
    @(negedge clk);
    Address = addr;
    MemRead = 1'b1;
    @(posedge clk);
    #1;
    data    = ReadData;
    hit     = Hit;
    MemRead = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    Address   = addr;
    WriteData = data;
    MemWrite  = 1'b1;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
  endtask

  task automatic read_check(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    logic        h;
    do_read(addr, d, h);
    check(tag, d, exp);
    check({tag, "_hit"}, {31'd0, h}, 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic        h;
    reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    Address = '0; WriteData = '0; PortIn = 8'h00;
    #3;
    check("rst_portout", PortOut, 32'd0);
    check("rst_hit", {31'd0, Hit}, 32'd0);
    check("rst_rdata", ReadData, 32'd0);
    check("rst_irq", {31'd0, Irq}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Reset values of every register
    read_check(BASE + 32'h00, 32'h0000_0000, "rst_port_out");
    read_check(BASE + 32'h04, 32'h0000_0000, "rst_port_in");
    read_check(BASE + 32'h08, 32'h0000_0000, "rst_edge");
    read_check(BASE + 32'h0C, 32'h0000_0000, "rst_edge_mask");
    read_check(BASE + 32'h10, 32'h0000_0000, "rst_ctrl");
    read_check(BASE + 32'h14, 32'h0000_0000, "rst_count");
    read_check(BASE + 32'h18, 32'hFFFF_FFFF, "rst_cmp");
    read_check(BASE + 32'h1C, 32'h0000_0000, "rst_status");
    @(posedge clk); #1;
    check("idle_hit", {31'd0, Hit}, 32'd0);
    check("idle_rdata", ReadData, 32'd0);

    // Reset asserted while read data is presented
    @(negedge clk);
    Address = BASE + 32'h18;
    MemRead = 1'b1;
    @(posedge clk); #1;
    check("pend_hit", {31'd0, Hit}, 32'd1);
    check("pend_rdata", ReadData, 32'hFFFF_FFFF);
    #2 reset = 1'b0;
    #1;
    check("pend_rst_hit", {31'd0, Hit}, 32'd0);
    check("pend_rst_rdata", ReadData, 32'd0);
    MemRead = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // PORT_OUT write/readback and ignored accesses
    do_write(BASE + 32'h00, 32'hDEAD_BEEF);
    check("portout_wr", PortOut, 32'hDEAD_BEEF);
    read_check(BASE + 32'h00, 32'hDEAD_BEEF, "portout_rd");
    do_write(BASE + 32'h20, 32'h1234_5678);
    check("oow_wr", PortOut, 32'hDEAD_BEEF);
    do_write(BASE + 32'h01, 32'h1234_5678);
    check("misal_wr", PortOut, 32'hDEAD_BEEF);
    do_read(BASE + 32'h20, d, h);
    check("oow_rd_hit", {31'd0, h}, 32'd0);
    check("oow_rd_data", d, 32'd0);
    do_read(BASE + 32'h01, d, h);
    check("misal_rd_hit", {31'd0, h}, 32'd0);
    check("misal_rd_data", d, 32'd0);

    // PortIn synchronizer latency and edge capture
    @(negedge clk);
    PortIn = 8'h05;
    read_check(BASE + 32'h04, 32'h0000_0000, "portin_1edge");
    read_check(BASE + 32'h04, 32'h0000_0005, "portin_2edge");
    read_check(BASE + 32'h08, 32'h0000_0005, "edge_set");
    do_write(BASE + 32'h0C, 32'h0000_0004);
    check("edge_irq_on", {31'd0, Irq}, 32'd1);
    do_write(BASE + 32'h08, 32'h0000_0004);
    check("edge_irq_off", {31'd0, Irq}, 32'd0);
    read_check(BASE + 32'h08, 32'h0000_0001, "edge_w1c");

    // New rise on bit1 lands on the same edge as a W1C of bit1: set wins
    @(negedge clk);
    PortIn = 8'h07;
    @(posedge clk);
    @(posedge clk);
    #1;
    do_write(BASE + 32'h08, 32'h0000_0002);
    read_check(BASE + 32'h08, 32'h0000_0003, "edge_set_wins");

    // Timer: CMP=3 gives period 4
    do_write(BASE + 32'h18, 32'd3);
    do_write(BASE + 32'h10, 32'd3);
    read_check(BASE + 32'h14, 32'd0, "cnt0");
    read_check(BASE + 32'h14, 32'd1, "cnt1");
    read_check(BASE + 32'h14, 32'd2, "cnt2");
    check("pre_tick_irq", {31'd0, Irq}, 32'd0);
    read_check(BASE + 32'h14, 32'd3, "cnt3");
    read_check(BASE + 32'h14, 32'd0, "cnt_wrap");
    check("tick_irq", {31'd0, Irq}, 32'd1);
    read_check(BASE + 32'h1C, 32'd1, "tick_set");
    do_write(BASE + 32'h1C, 32'd1);
    check("tick_clr_irq", {31'd0, Irq}, 32'd0);
    do_write(BASE + 32'h1C, 32'd1);
    read_check(BASE + 32'h1C, 32'd1, "tick_set_wins");

    // COUNT write overrides the running timer; disable freezes it
    do_write(BASE + 32'h14, 32'd100);
    read_check(BASE + 32'h14, 32'd100, "cnt_load");
    read_check(BASE + 32'h14, 32'd101, "cnt_load_inc");
    do_write(BASE + 32'h10, 32'd0);
    read_check(BASE + 32'h14, 32'd103, "cnt_freeze_a");
    read_check(BASE + 32'h14, 32'd103, "cnt_freeze_b");
    check("ie_off_irq", {31'd0, Irq}, 32'd0);

    // Simultaneous read and write: write only
    @(negedge clk);
    Address   = BASE + 32'h0C;
    WriteData = 32'h0000_00FF;
    MemRead   = 1'b1;
    MemWrite  = 1'b1;
    @(posedge clk); #1;
    check("rw_hit", {31'd0, Hit}, 32'd0);
    check("rw_rdata", ReadData, 32'd0);
    check("rw_irq", {31'd0, Irq}, 32'd1);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    read_check(BASE + 32'h0C, 32'h0000_00FF, "rw_mask");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
